mmio_controller: RTL and testbench

Parametrised memory-mapped I/O controller serving the core's I/O address space (address bit 22 set). It is the successor to the fixed LED-only I/O driver. It provides:
- a configurable-width LED register,
- a free-running 32-bit cycle counter,
- a buffered 8N1 UART transmitter with a FIFO and status/overflow reporting.

Loads read combinationally so the single-cycle core sees data in the same cycle; stores commit on the clock edge.

---
 rtl/mmio_controller.sv | 171 +++++++++++++++++
 tb/tb_mmio_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_controller.sv
// I/O-space controller: LED register, free-running cycle counter
// and a FIFO-buffered 8N1 UART transmitter.
module mmio_controller #(
  parameter int LED_W        = 5,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] leds,
  output logic             uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BMAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [2:0]       off;
  logic             wr;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             busy;
  logic             unused_addr;

  logic [LED_W-1:0] led_q;
  logic [31:0]      cyc_q;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             ovf;
  logic [1:0]       state;
  logic [7:0]       shreg;
  logic [BW-1:0]    bitcnt;
  logic [2:0]       idx;
  logic             tx_q;

  assign off         = addr[4:2];
  assign unused_addr = ^{addr[31:5], addr[1:0]};
  assign wr          = sel & we;
  assign push_req    = wr & (off == 3'd1);
  assign full        = (cnt == DEPTH);
  assign empty       = (cnt == '0);
  assign push        = push_req & ~full;
  assign pop         = (state == IDLE) & ~empty;
  assign busy        = (state != IDLE);
  assign leds        = led_q;
  assign uart_tx     = tx_q;

  // LED register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) led_q <= '0;
    else if (wr && off == 3'd0) led_q <= wdata[LED_W-1:0];
  end

  // Cycle counter: a store replaces the increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_q <= '0;
    else if (wr && off == 3'd3) cyc_q <= wdata;
    else cyc_q <= cyc_q + 32'd1;
  end

  // FIFO storage; contents are dead once the pointers reset
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (push && !pop) cnt <= cnt + (AW + 1)'(1);
      else if (pop && !push) cnt <= cnt - (AW + 1)'(1);
    end
  end

  // Sticky overflow; a dropped push beats a clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf <= 1'b0;
    else if (push_req && full) ovf <= 1'b1;
    else if (wr && off == 3'd2 && wdata[3]) ovf <= 1'b0;
  end

  // UART frame sequencer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      idx    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            shreg  <= mem[rptr];
            bitcnt <= '0;
            state  <= START;
          end
        end
        START: begin
          if (bitcnt == BMAX) begin
            bitcnt <= '0;
            idx    <= '0;
            state  <= DATA;
          end else begin
            bitcnt <= bitcnt + BW'(1);
          end
        end
        DATA: begin
          if (bitcnt == BMAX) begin
            bitcnt <= '0;
            idx    <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            bitcnt <= bitcnt + BW'(1);
          end
        end
        STOP: begin
          if (bitcnt == BMAX) begin
            bitcnt <= '0;
            state  <= IDLE;
          end else begin
            bitcnt <= bitcnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered line driver, one cycle behind the sequencer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_q <= 1'b1;
    else if (state == START) tx_q <= 1'b0;
    else if (state == DATA) tx_q <= shreg[idx];
    else tx_q <= 1'b1;
  end

  // Combinational read mux
  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (1'b1)
        (off == 3'd0): rdata[LED_W-1:0] = led_q;
        (off == 3'd2): rdata[3:0] = {ovf, busy, empty, full};
        (off == 3'd3): rdata = cyc_q;
        default:       rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_controller.sv
// Bench for mmio_controller: register table, hand-written UART
// sequences and a randomized run against a behavioural model.
module tb_mmio_controller;

  localparam int LW  = 5;
  localparam int FD  = 4;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sel = 1'b0;
  logic          we = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic [LW-1:0] leds;
  logic          uart_tx;

  int vec = 0;
  int bad = 0;

  mmio_controller #(
    .LED_W(LW),
    .FIFO_DEPTH(FD),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sel(sel),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .leds(leds),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic s, input logic w,
                        input logic [2:0] o, input logic [31:0] d);
    logic [31:0] a;
    a = $urandom;
    a[4:2] = o;
    sel = s;
    we = w;
    addr = a;
    wdata = d;
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // behavioural model
  logic [7:0]    m_q[$];
  logic [LW-1:0] m_led;
  logic [31:0]   m_cyc;
  logic          m_ovf;
  logic          m_busy;
  int            m_t;
  logic [7:0]    m_byte;
  logic          m_tx;

  task automatic m_reset();
    m_q.delete();
    m_led = '0;
    m_cyc = '0;
    m_ovf = 1'b0;
    m_busy = 1'b0;
    m_t = 0;
    m_byte = '0;
    m_tx = 1'b1;
  endtask

  function automatic logic [31:0] m_read(input logic s,
                                         input logic [2:0] o);
    logic [31:0] r;
    r = '0;
    if (s) begin
      case (o)
        3'd0: r = {{(32-LW){1'b0}}, m_led};
        3'd2: r = {28'd0, m_ovf, m_busy,
                   m_q.size() == 0, m_q.size() == FD};
        3'd3: r = m_cyc;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic m_step(input logic s, input logic w,
                        input logic [2:0] o, input logic [31:0] d);
    bit full_pre;
    bit empty_pre;
    bit wr;
    full_pre = (m_q.size() == FD);
    empty_pre = (m_q.size() == 0);
    wr = s & w;
    m_tx = m_busy ? fbit(m_byte, m_t / CPB) : 1'b1;
    if (m_busy) begin
      m_t++;
      if (m_t == 10 * CPB) m_busy = 1'b0;
    end else if (!empty_pre) begin
      m_byte = m_q.pop_front();
      m_busy = 1'b1;
      m_t = 0;
    end
    if (wr && o == 3'd0) m_led = d[LW-1:0];
    if (wr && o == 3'd1) begin
      if (full_pre) m_ovf = 1'b1;
      else m_q.push_back(d[7:0]);
    end else if (wr && o == 3'd2 && d[3]) begin
      m_ovf = 1'b0;
    end
    m_cyc = (wr && o == 3'd3) ? d : m_cyc + 32'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, 1'b0, 3'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_reset();
  endtask

  typedef struct {
    logic        ws;
    logic [2:0]  woff;
    logic [31:0] wd;
    logic        rs;
    logic [2:0]  roff;
    logic [31:0] erd;
    logic [4:0]  eled;
  } vec_t;

  vec_t tbl[11];
  logic [7:0] bst[6];

  initial begin
    tbl[0]  = '{1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 3'd0, 32'h1F, 5'h1F};
    tbl[1]  = '{1'b0, 3'd0, 32'h00000000, 1'b1, 3'd0, 32'h1F, 5'h1F};
    tbl[2]  = '{1'b1, 3'd0, 32'h00000012, 1'b1, 3'd0, 32'h12, 5'h12};
    tbl[3]  = '{1'b1, 3'd0, 32'h00000012, 1'b0, 3'd0, 32'h00, 5'h12};
    tbl[4]  = '{1'b1, 3'd5, 32'hDEADBEEF, 1'b1, 3'd0, 32'h12, 5'h12};
    tbl[5]  = '{1'b1, 3'd4, 32'hFFFFFFFF, 1'b1, 3'd4, 32'h00, 5'h12};
    tbl[6]  = '{1'b1, 3'd6, 32'hFFFFFFFF, 1'b1, 3'd5, 32'h00, 5'h12};
    tbl[7]  = '{1'b1, 3'd7, 32'hFFFFFFFF, 1'b1, 3'd6, 32'h00, 5'h12};
    tbl[8]  = '{1'b1, 3'd2, 32'h00000008, 1'b1, 3'd7, 32'h00, 5'h12};
    tbl[9]  = '{1'b1, 3'd2, 32'hFFFFFFFF, 1'b1, 3'd2, 32'h02, 5'h12};
    tbl[10] = '{1'b1, 3'd0, 32'h00000000, 1'b1, 3'd1, 32'h00, 5'h00};
    bst = '{8'h11, 8'h22, 8'h33, 8'h54, 8'hA7, 8'h66};

    do_reset();
    set_in(1'b1, 1'b0, 3'd2, 32'd0);
    #1;
    chk("reset_status", rdata, 32'h2);
    chk("reset_leds", {27'd0, leds}, 32'd0);
    chk("reset_tx", {31'd0, uart_tx}, 32'd1);

    // register table
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      set_in(tbl[i].ws, 1'b1, tbl[i].woff, tbl[i].wd);
      @(negedge clk);
      set_in(tbl[i].rs, 1'b0, tbl[i].roff, 32'd0);
      #1;
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].erd);
      chk($sformatf("tbl%0d_leds", i), {27'd0, leds},
          {27'd0, tbl[i].eled});
    end

    // cycle counter wrap
    @(negedge clk);
    set_in(1'b1, 1'b1, 3'd3, 32'hFFFFFFFE);
    @(negedge clk);
    set_in(1'b1, 1'b0, 3'd3, 32'd0);
    #1 chk("cyc_load", rdata, 32'hFFFFFFFE);
    @(negedge clk);
    #1 chk("cyc_max", rdata, 32'hFFFFFFFF);
    @(negedge clk);
    #1 chk("cyc_wrap", rdata, 32'h0);

    // single byte frame
    @(negedge clk);
    set_in(1'b1, 1'b1, 3'd1, 32'hA5);
    @(negedge clk);
    set_in(1'b1, 1'b0, 3'd2, 32'd0);
    for (int i = 0; i < 45; i++) begin
      int k;
      logic etx;
      @(negedge clk);
      #1;
      k = (i - 1) / CPB;
      etx = (i == 0 || k >= 10) ? 1'b1 : fbit(8'hA5, k);
      chk($sformatf("a5_tx%0d", i), {31'd0, uart_tx}, {31'd0, etx});
      chk($sformatf("a5_st%0d", i), rdata,
          (i <= 10 * CPB - 1) ? 32'h6 : 32'h2);
    end

    // burst of six into a four-entry FIFO
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      set_in(1'b1, 1'b1, 3'd1, {24'd0, bst[j]});
    end
    @(negedge clk);
    set_in(1'b1, 1'b0, 3'd2, 32'd0);
    #1 chk("burst_status", rdata, 32'hD);
    for (int i = 5; i <= 220; i++) begin
      int f;
      int r;
      logic etx;
      @(negedge clk);
      if (i == 10) set_in(1'b1, 1'b1, 3'd2, 32'h8);
      else set_in(1'b1, 1'b0, 3'd2, 32'd0);
      #1;
      f = (i - 1) / (10 * CPB + 1);
      r = (i - 1) % (10 * CPB + 1);
      if (f >= 5 || r >= 10 * CPB) etx = 1'b1;
      else etx = fbit(bst[f], r / CPB);
      chk($sformatf("burst_tx%0d", i), {31'd0, uart_tx}, {31'd0, etx});
      if (i == 11) chk("ovf_clear", rdata, 32'h5);
      if (i == 220) chk("burst_done", rdata, 32'h2);
    end

    // reset in the middle of a frame
    @(negedge clk);
    set_in(1'b1, 1'b1, 3'd0, 32'h15);
    @(negedge clk);
    set_in(1'b1, 1'b1, 3'd1, 32'h3C);
    @(negedge clk);
    set_in(1'b1, 1'b1, 3'd1, 32'h3D);
    repeat (12) begin
      @(negedge clk);
      set_in(1'b0, 1'b0, 3'd0, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b1, 1'b0, 3'd2, 32'd0);
    #1;
    chk("rst_status", rdata, 32'h2);
    chk("rst_leds", {27'd0, leds}, 32'd0);
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    set_in(1'b1, 1'b0, 3'd3, 32'd0);
    #1 chk("rst_cyc", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rel_cyc0", rdata, 32'd0);
    @(negedge clk);
    #1 chk("rel_cyc1", rdata, 32'd1);
    @(negedge clk);
    #1 chk("rel_cyc2", rdata, 32'd2);
    set_in(1'b1, 1'b0, 3'd2, 32'd0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      chk("rel_tx", {31'd0, uart_tx}, 32'd1);
      chk("rel_status", rdata, 32'h2);
    end

    // randomized run against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int r;
      logic s;
      logic w;
      logic [2:0] o;
      r = $urandom_range(0, 99);
      s = (r >= 8);
      w = (c < 2000) ? (r < 40) : (r < 14);
      if (!s) w = $urandom_range(0, 1) == 1;
      o = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      set_in(s, w, o, $urandom);
      #1;
      chk("rnd_rdata", rdata, m_read(s, o));
      chk("rnd_leds", {27'd0, leds}, {27'd0, m_led});
      chk("rnd_tx", {31'd0, uart_tx}, {31'd0, m_tx});
      @(posedge clk);
      m_step(s, w, o, wdata);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
